// File: rtl/divider_if.sv
// Request/response signals of the 32-bit iterative divider.
// The master issues operations and the slave (the divider) returns results.
interface divider_if;
    logic        valid;
    logic [1:0]  divop;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    modport master (
        output valid,
        output divop,
        output dividend,
        output divisor,
        input  busy,
        input  ready,
        input  result
    );

    modport slave (
        input  valid,
        input  divop,
        input  dividend,
        input  divisor,
        output busy,
        output ready,
        output result
    );
endinterface

// File: rtl/divider.sv
// Fixed-latency 32-bit restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; the result register updates only on entry to DONE.
module divider (
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;
    localparam logic [31:0] IntMin  = 32'h8000_0000;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] dvs_mag_q, dvs_mag_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  count_q, count_d;

    // Operand magnitudes at the request boundary
    logic        in_signed;
    logic [31:0] in_dvd_mag;
    logic [31:0] in_dvs_mag;

    always_comb begin
        in_signed  = ~bus.divop[0];
        in_dvd_mag = (in_signed && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
        in_dvs_mag = (in_signed && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
    end

    // One restoring step: the quotient register doubles as the dividend shifter
    logic [32:0] partial;
    logic [32:0] trial;
    logic [31:0] step_quot;
    logic [31:0] step_rem;

    always_comb begin
        partial   = {rem_q, quot_q[31]};
        trial     = partial - {1'b0, dvs_mag_q};
        step_quot = {quot_q[30:0], ~trial[32]};
        step_rem  = trial[32] ? partial[31:0] : trial[31:0];
    end

    // Sign correction and special-case selection for the final result
    logic        op_signed;
    logic        op_is_rem;
    logic        neg_quot;
    logic        neg_rem;
    logic        div_zero;
    logic        overflow;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_val;

    always_comb begin
        op_signed = ~op_q[0];
        op_is_rem = op_q[1];
        neg_quot  = op_signed & (dividend_q[31] ^ divisor_q[31]);
        neg_rem   = op_signed & dividend_q[31];
        div_zero  = (divisor_q == 32'd0);
        overflow  = op_signed & (dividend_q == IntMin) & (divisor_q == AllOnes);
        quot_fix  = neg_quot ? (32'd0 - step_quot) : step_quot;
        rem_fix   = neg_rem  ? (32'd0 - step_rem)  : step_rem;

        if (div_zero) begin
            final_val = op_is_rem ? dividend_q : AllOnes;
        end else if (overflow) begin
            final_val = op_is_rem ? 32'd0 : IntMin;
        end else begin
            final_val = op_is_rem ? rem_fix : quot_fix;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        dvs_mag_d  = dvs_mag_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        result_d   = result_q;
        count_d    = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    op_d       = bus.divop;
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    dvs_mag_d  = in_dvs_mag;
                    quot_d     = in_dvd_mag;
                    rem_d      = 32'd0;
                    count_d    = 6'd0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                quot_d  = step_quot;
                rem_d   = step_rem;
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    result_d = final_val;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= 2'b00;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            dvs_mag_q  <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            result_q   <= 32'd0;
            count_q    <= 6'd0;
        end else begin
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            dvs_mag_q  <= dvs_mag_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            count_q    <= count_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.ready  = (state_q == StDone);
    assign bus.result = result_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor
// pops and compares them (value and latency) on each ready strobe.
module tb_divider;

    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    divider_if bus ();

    divider dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [31:0] exp;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: one pop per ready strobe; ready must never last two cycles
    logic prev_ready;
    initial prev_ready = 1'b0;
    always @(negedge clk) begin
        if (resetn && bus.ready) begin
            exp_t e;
            check("ready single-cycle", {31'd0, prev_ready}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected ready: got result %h, required no ready", bus.result);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.result, e.exp);
                check({e.name, " latency"}, cyc - e.acc, 32'd32);
            end
        end
        prev_ready = bus.ready;
    end

    // Waits for idle, lets the next edge accept, and records the expectation
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input bit keep,
                         output int acc);
        int guard;
        bus.divop    = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.valid    = 1'b1;
        guard        = 0;
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept timeout: got busy stuck, required idle", name);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{exp: exp, acc: acc, name: name});
        if (!keep) bus.valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain timeout: got %0d pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;

        n_cmp        = 0;
        n_bad        = 0;
        cyc          = 0;
        resetn       = 1'b0;
        bus.valid    = 1'b0;
        bus.divop    = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;

        #12;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset ready", {31'd0, bus.ready}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time
        issue(OpDivu, 32'd100, 32'd7, 32'd14, "divu 100/7", 1'b0, acc1);
        check("busy after accept", {31'd0, bus.busy}, 32'd1);
        drain("divu 100/7");
        issue(OpRemu, 32'd100, 32'd7, 32'd2, "remu 100/7", 1'b0, acc1);
        check("result held during calc", bus.result, 32'd14);
        drain("remu 100/7");
        issue(OpDiv, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, "div -100/7", 1'b0, acc1);
        drain("div -100/7");
        issue(OpRem, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, "rem -100/7", 1'b0, acc1);
        drain("rem -100/7");
        issue(OpRem, 32'd100, 32'hFFFFFFF9, 32'd2, "rem 100/-7", 1'b0, acc1);
        drain("rem 100/-7");
        issue(OpDivu, 32'h12345678, 32'd0, 32'hFFFFFFFF, "divu by zero", 1'b0, acc1);
        drain("divu by zero");
        issue(OpRem, 32'h12345678, 32'd0, 32'h12345678, "rem by zero", 1'b0, acc1);
        drain("rem by zero");
        issue(OpDiv, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, "div -100 by zero", 1'b0, acc1);
        drain("div -100 by zero");
        issue(OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div overflow", 1'b0, acc1);
        drain("div overflow");
        issue(OpRem, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem overflow", 1'b0, acc1);
        drain("rem overflow");
        issue(OpDivu, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, "divu max/16", 1'b0, acc1);
        drain("divu max/16");
        issue(OpRemu, 32'hFFFFFFFF, 32'd16, 32'h0000000F, "remu max/16", 1'b0, acc1);
        drain("remu max/16");

        // valid held high: second op accepted two edges after DONE, operands swapped mid-flight
        issue(OpDivu, 32'd1000, 32'd10, 32'd100, "b2b first", 1'b1, acc1);
        issue(OpDiv, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "b2b second", 1'b0, acc2);
        check("b2b accept spacing", acc2 - acc1, 32'd34);
        drain("b2b");

        // Request pulsed mid-calc must be ignored
        issue(OpDivu, 32'd50, 32'd5, 32'd10, "ignore inflight", 1'b0, acc1);
        repeat (10) @(negedge clk);
        bus.divop    = OpDivu;
        bus.dividend = 32'd99;
        bus.divisor  = 32'd3;
        bus.valid    = 1'b1;
        @(negedge clk);
        bus.valid    = 1'b0;
        drain("ignore inflight");
        repeat (40) @(negedge clk);

        // Reset at step 10 aborts with no ready strobe
        issue(OpDivu, 32'd100, 32'd7, 32'd14, "aborted", 1'b0, acc1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        sb.delete();
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort ready", {31'd0, bus.ready}, 32'd0);
        check("abort result", bus.result, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        issue(OpDivu, 32'd9, 32'd3, 32'd3, "divu 9/3 after reset", 1'b0, acc1);
        drain("divu 9/3 after reset");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
